writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit_if.sv | 27 ++
 rtl/writeback_unit.sv | 107 ++++++++++
 tb/tb_writeback_unit.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/writeback_unit_if.sv
// Instruction handshake between the pipeline front end and the writeback unit.
// The master presents one instruction per cycle; the slave answers with in_ready.
interface writeback_unit_if #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned REG_SEL_BITS = 5
);
  logic                    in_valid;
  logic                    in_ready;
  logic                    in_reg_write;
  logic [REG_SEL_BITS-1:0] in_rd;
  logic                    in_mem_read;
  logic [2:0]              in_load_type;
  logic [1:0]              in_byte_off;
  logic [DATA_WIDTH-1:0]   in_alu_result;

  modport master (
    output in_valid, in_reg_write, in_rd, in_mem_read,
           in_load_type, in_byte_off, in_alu_result,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_reg_write, in_rd, in_mem_read,
           in_load_type, in_byte_off, in_alu_result,
    output in_ready
  );
endinterface

// File: rtl/writeback_unit.sv
// Writeback stage: retires ALU results in one cycle, waits on memory for loads,
// formats load data (LB/LH/LW/LBU/LHU) and drives registered register-file writes.
module writeback_unit #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned REG_SEL_BITS = 5
) (
  input  logic                    clock,
  input  logic                    reset,
  writeback_unit_if.slave         bus,
  input  logic                    mem_valid,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  output logic                    wEn,
  output logic [REG_SEL_BITS-1:0] write_sel,
  output logic [DATA_WIDTH-1:0]   write_data,
  output logic [31:0]             retire_count
);

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } state_t;

  state_t                  state;
  logic                    reg_write_q;
  logic [REG_SEL_BITS-1:0] rd_q;
  logic [2:0]              load_type_q;
  logic [1:0]              byte_off_q;
  logic [31:0]             retire_q;

  logic                    accept;
  logic                    alu_wen;
  logic                    load_wen;
  logic [7:0]              byte_v;
  logic [15:0]             half_v;
  logic [DATA_WIDTH-1:0]   load_data;

  assign bus.in_ready = (state == IDLE);
  assign accept       = bus.in_valid && bus.in_ready;
  assign retire_count = retire_q;

  assign alu_wen  = bus.in_reg_write && (bus.in_rd != '0);
  assign load_wen = reg_write_q && (rd_q != '0);

  // Halfword selection uses only byte_off[1]; misaligned halfword offsets fold down.
  always_comb begin
    byte_v    = mem_rdata[8*byte_off_q +: 8];
    half_v    = mem_rdata[16*byte_off_q[1] +: 16];
    load_data = mem_rdata;
    case (load_type_q)
      3'b000:  load_data = {{(DATA_WIDTH-8){byte_v[7]}}, byte_v};
      3'b001:  load_data = {{(DATA_WIDTH-16){half_v[15]}}, half_v};
      3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, byte_v};
      3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, half_v};
      default: load_data = mem_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      wEn         <= 1'b0;
      write_sel   <= '0;
      write_data  <= '0;
      retire_q    <= '0;
      reg_write_q <= 1'b0;
      rd_q        <= '0;
      load_type_q <= '0;
      byte_off_q  <= '0;
    end else begin
      wEn <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            reg_write_q <= bus.in_reg_write;
            rd_q        <= bus.in_rd;
            load_type_q <= bus.in_load_type;
            byte_off_q  <= bus.in_byte_off;
            if (bus.in_mem_read) begin
              state <= WAIT_MEM;
            end else begin
              // Completion without a write (rd=0 or no reg_write) still retires.
              wEn      <= alu_wen;
              retire_q <= retire_q + 32'd1;
              if (alu_wen) begin
                write_sel  <= bus.in_rd;
                write_data <= bus.in_alu_result;
              end
            end
          end
        end
        WAIT_MEM: begin
          if (mem_valid) begin
            wEn      <= load_wen;
            retire_q <= retire_q + 32'd1;
            state    <= IDLE;
            if (load_wen) begin
              write_sel  <= rd_q;
              write_data <= load_data;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Randomized bench for writeback_unit against a transaction-level reference model.
module tb_writeback_unit;
  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          mem_valid;
  logic [DW-1:0] mem_rdata;
  logic          wEn;
  logic [RW-1:0] write_sel;
  logic [DW-1:0] write_data;
  logic [31:0]   retire_count;

  always #5 clock = ~clock;

  writeback_unit_if #(.DATA_WIDTH(DW), .REG_SEL_BITS(RW)) bus ();

  writeback_unit #(.DATA_WIDTH(DW), .REG_SEL_BITS(RW)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .mem_valid    (mem_valid),
    .mem_rdata    (mem_rdata),
    .wEn          (wEn),
    .write_sel    (write_sel),
    .write_data   (write_data),
    .retire_count (retire_count)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [31:0] exp_count;
  logic [31:0] exp_sel;
  logic [31:0] exp_data;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, want);
  endtask

  // Reference load formatting from the ISA rules, using plain integer arithmetic.
  function automatic logic [31:0] fmt_load(input logic [2:0] t, input logic [1:0] off,
                                           input logic [31:0] w);
    int unsigned b;
    int unsigned h;
    b = (w >> (8 * int'(off))) % 256;
    h = (w >> (16 * (int'(off) / 2))) % 65536;
    case (t)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  task automatic expect_result(input logic wr, input logic [RW-1:0] rd, input logic [31:0] data);
    logic writes;
    writes    = wr && (rd != 0);
    exp_count = exp_count + 32'd1;
    if (writes) begin
      exp_sel  = 32'(rd);
      exp_data = data;
    end
    check("wEn", {31'b0, wEn}, {31'b0, writes});
    check("write_sel", 32'(write_sel), exp_sel);
    check("write_data", write_data, exp_data);
    check("retire_count", retire_count, exp_count);
  endtask

  task automatic expect_quiet(input string tag);
    check({tag, "_wEn"}, {31'b0, wEn}, 32'd0);
    check({tag, "_count"}, retire_count, exp_count);
  endtask

  task automatic reset_model();
    exp_count = '0;
    exp_sel   = '0;
    exp_data  = '0;
  endtask

  task automatic alu_one(input logic [RW-1:0] rd, input logic wr, input logic [31:0] alu);
    bus.in_valid      = 1'b1;
    bus.in_mem_read   = 1'b0;
    bus.in_reg_write  = wr;
    bus.in_rd         = rd;
    bus.in_load_type  = 3'($urandom);
    bus.in_byte_off   = 2'($urandom);
    bus.in_alu_result = alu;
    mem_valid         = 1'($urandom);
    mem_rdata         = $urandom;
    check("ready_idle", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clock);
    expect_result(wr, rd, alu);
  endtask

  task automatic load_op(input logic [RW-1:0] rd, input logic wr, input logic [2:0] t,
                         input logic [1:0] off, input logic [31:0] word, input int unsigned delay);
    bus.in_valid      = 1'b1;
    bus.in_mem_read   = 1'b1;
    bus.in_reg_write  = wr;
    bus.in_rd         = rd;
    bus.in_load_type  = t;
    bus.in_byte_off   = off;
    bus.in_alu_result = $urandom;
    mem_valid         = 1'b0;
    check("ready_idle", {31'b0, bus.in_ready}, 32'd1);
    @(negedge clock);
    for (int unsigned i = 0; i < delay; i++) begin
      bus.in_valid      = 1'($urandom);
      bus.in_mem_read   = 1'($urandom);
      bus.in_reg_write  = 1'($urandom);
      bus.in_rd         = RW'($urandom);
      bus.in_load_type  = 3'($urandom);
      bus.in_byte_off   = 2'($urandom);
      mem_rdata         = $urandom;
      check("ready_wait", {31'b0, bus.in_ready}, 32'd0);
      expect_quiet("wait");
      @(negedge clock);
    end
    bus.in_valid = 1'b0;
    mem_valid    = 1'b1;
    mem_rdata    = word;
    check("ready_wait", {31'b0, bus.in_ready}, 32'd0);
    @(negedge clock);
    mem_valid = 1'b0;
    expect_result(wr, rd, fmt_load(t, off, word));
    check("ready_after", {31'b0, bus.in_ready}, 32'd1);
  endtask

  function automatic logic [RW-1:0] rand_rd();
    return ($urandom_range(0, 3) == 0) ? '0 : RW'($urandom);
  endfunction

  initial begin
    bus.in_valid      = 1'b0;
    bus.in_mem_read   = 1'b0;
    bus.in_reg_write  = 1'b0;
    bus.in_rd         = '0;
    bus.in_load_type  = '0;
    bus.in_byte_off   = '0;
    bus.in_alu_result = '0;
    mem_valid         = 1'b0;
    mem_rdata         = '0;
    reset_model();

    repeat (2) @(negedge clock);
    check("rst_wEn", {31'b0, wEn}, 32'd0);
    check("rst_sel", 32'(write_sel), 32'd0);
    check("rst_data", write_data, 32'd0);
    check("rst_count", retire_count, 32'd0);
    check("rst_ready", {31'b0, bus.in_ready}, 32'd1);
    reset = 1'b0;

    alu_one(5'd5, 1'b1, 32'h0000_1234);
    bus.in_valid = 1'b0;
    load_op(5'd3, 1'b1, 3'b000, 2'd2, 32'h0080_FF11, 2);
    load_op(5'd9, 1'b1, 3'b101, 2'd3, 32'hBEEF_0000, 1);
    load_op(5'd10, 1'b1, 3'b001, 2'd3, 32'hBEEF_0000, 0);
    alu_one(5'd0, 1'b1, 32'hDEAD_BEEF);
    alu_one(5'd4, 1'b0, 32'h5555_AAAA);
    alu_one(5'd31, 1'b1, 32'hFFFF_FFFF);
    bus.in_valid = 1'b0;

    // mem_valid while idle must be ignored
    mem_valid = 1'b1;
    mem_rdata = 32'h1357_9BDF;
    @(negedge clock);
    mem_valid = 1'b0;
    expect_quiet("idle_mem");

    for (int unsigned it = 0; it < 200; it++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          for (int unsigned k = 0; k < $urandom_range(1, 4); k++)
            alu_one(rand_rd(), 1'($urandom), $urandom);
          bus.in_valid = 1'b0;
        end
        2: load_op(rand_rd(), 1'($urandom), 3'($urandom), 2'($urandom), $urandom,
                   $urandom_range(0, 3));
        default: begin
          bus.in_valid = 1'b0;
          mem_valid    = 1'($urandom);
          mem_rdata    = $urandom;
          @(negedge clock);
          mem_valid = 1'b0;
          expect_quiet("idle");
        end
      endcase
    end

    // Reset while waiting on memory, with mem_valid coincident and after
    bus.in_valid     = 1'b1;
    bus.in_mem_read  = 1'b1;
    bus.in_reg_write = 1'b1;
    bus.in_rd        = 5'd7;
    bus.in_load_type = 3'b010;
    @(negedge clock);
    bus.in_valid = 1'b0;
    check("pre_rst_ready", {31'b0, bus.in_ready}, 32'd0);
    reset     = 1'b1;
    mem_valid = 1'b1;
    mem_rdata = 32'hCAFE_F00D;
    @(negedge clock);
    reset = 1'b0;
    reset_model();
    expect_quiet("rst_wait");
    check("rst_wait_ready", {31'b0, bus.in_ready}, 32'd1);
    check("rst_wait_sel", 32'(write_sel), 32'd0);
    check("rst_wait_data", write_data, 32'd0);
    @(negedge clock);
    mem_valid = 1'b0;
    expect_quiet("late_mem");
    check("late_mem_ready", {31'b0, bus.in_ready}, 32'd1);

    // Counter wrap from a preset all-ones value
    force dut.retire_q = 32'hFFFF_FFFF;
    @(negedge clock);
    release dut.retire_q;
    exp_count = 32'hFFFF_FFFF;
    alu_one(5'd1, 1'b1, 32'h0BAD_CAFE);
    bus.in_valid = 1'b0;
    check("wrap_zero", retire_count, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
